// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_FLUSH = 2'd2
    } pipe_ctrl_state_e;

    // Pipeline register indices, upstream to downstream.
    localparam int NUM_PIPE_REGS = 4;
    localparam int STG_IF_ID     = 0;
    localparam int STG_ID_EX     = 1;
    localparam int STG_EX_MEM    = 2;
    localparam int STG_MEM_WB    = 3;

    // PC source select encodings.
    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP   = 2'd2;

    localparam logic [NUM_PIPE_REGS-1:0] ALL_REGS = '1;

    // A register inserts a bubble when the stage feeding it is held: the IF/ID
    // register is fed by the PC, every other register by the register before it.
    function automatic logic [NUM_PIPE_REGS-1:0] bubble_of(
        input logic                     pc_en,
        input logic [NUM_PIPE_REGS-1:0] stall
    );
        return {stall[NUM_PIPE_REGS-2:0], ~pc_en};
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. Writes to x0 never create a dependency.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rd_live;
    logic src_match;

    // Pure combinational compare; the sequencer decides what to do with it.
    always_comb begin
        rd_live   = ex_valid & ex_is_load & (ex_rd != 5'd0);
        src_match = (id_rs1 == ex_rd) | (id_rs2 == ex_rd);
        hazard    = rd_live & id_valid & src_match;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Generates per-register stall,
// flush and bubble controls plus PC enable/select from load-use, data-memory
// wait, taken-branch and trap events. Holds control state only.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  RUN        | normal flow; redirect and load-use handled combinationally
//  MEM_WAIT   | data memory busy; front three registers held, MEM/WB bubbles
//  TRAP_FLUSH | trap taken; all registers flushed until the counter expires
//
// Event priority: trap > mem_wait > ex_redirect > load-use.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TRAP_FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W       = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     id_valid_i,
    input  logic [4:0]               id_rs1_i,
    input  logic [4:0]               id_rs2_i,
    input  logic                     ex_valid_i,
    input  logic                     ex_is_load_i,
    input  logic [4:0]               ex_rd_i,
    input  logic                     ex_redirect_i,
    input  logic                     mem_wait_i,
    input  logic                     trap_i,
    output logic                     pc_en_o,
    output logic [1:0]               pc_sel_o,
    output logic [NUM_PIPE_REGS-1:0] stall_o,
    output logic [NUM_PIPE_REGS-1:0] flush_o,
    output logic [NUM_PIPE_REGS-1:0] bubble_o,
    output logic [STALL_CNT_W-1:0]   stall_cnt_o
);

    // The trap cycle itself is the first flush cycle, so the counter only has
    // to cover the remaining TRAP_FLUSH_CYCLES-1 cycles.
    localparam int TCNT_W = (TRAP_FLUSH_CYCLES > 2) ? $clog2(TRAP_FLUSH_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TRAP_FLUSH_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    pipe_ctrl_state_e         state_q;
    pipe_ctrl_state_e         state_d;
    logic [TCNT_W-1:0]        tcnt_q;
    logic [TCNT_W-1:0]        tcnt_d;
    logic                     rst_done_q;
    logic                     load_use;
    logic                     stall_event;
    logic [STALL_CNT_W-1:0]   stall_cnt_q;

    load_use_detect u_load_use_detect (
        .id_valid   (id_valid_i),
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .ex_valid   (ex_valid_i),
        .ex_is_load (ex_is_load_i),
        .ex_rd      (ex_rd_i),
        .hazard     (load_use)
    );

    // Output decode and next-state selection, in event priority order.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        pc_en_o  = 1'b1;
        pc_sel_o = PC_SEL_SEQ;
        stall_o  = '0;
        flush_o  = '0;

        if (!rst_done_q) begin
            // Until the first clock after reset release, keep the pipe flushed
            // and the PC parked.
            pc_en_o = 1'b0;
            flush_o = ALL_REGS;
        end else if (trap_i) begin
            flush_o  = ALL_REGS;
            pc_sel_o = PC_SEL_TRAP;
            tcnt_d   = TCNT_LOAD;
            state_d  = (TRAP_FLUSH_CYCLES > 1) ? TRAP_FLUSH : RUN;
        end else if (state_q == TRAP_FLUSH) begin
            flush_o = ALL_REGS;
            pc_en_o = 1'b0;
            if (tcnt_q <= TCNT_ONE) begin
                tcnt_d  = '0;
                state_d = RUN;
            end else begin
                tcnt_d = tcnt_q - TCNT_ONE;
            end
        end else if (mem_wait_i) begin
            // EX is frozen, so redirect and load-use are not acted on here; they
            // are re-evaluated in the cycle mem_wait_i drops.
            pc_en_o              = 1'b0;
            stall_o[STG_IF_ID]   = 1'b1;
            stall_o[STG_ID_EX]   = 1'b1;
            stall_o[STG_EX_MEM]  = 1'b1;
            stall_o[STG_MEM_WB]  = 1'b0;
            state_d              = MEM_WAIT;
        end else begin
            state_d = RUN;
            if (ex_redirect_i) begin
                // A load-use stall in the same cycle is on the wrong path.
                flush_o[STG_IF_ID] = 1'b1;
                flush_o[STG_ID_EX] = 1'b1;
                pc_sel_o           = PC_SEL_BRANCH;
            end else if (load_use) begin
                pc_en_o            = 1'b0;
                stall_o[STG_IF_ID] = 1'b1;
            end
        end
    end

    assign bubble_o = bubble_of(pc_en_o, stall_o);

    // Sequencer state, trap flush counter and reset-release flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            tcnt_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            rst_done_q <= 1'b1;
        end
    end

    assign stall_event = rst_done_q & ((|stall_o) | ~pc_en_o);

    // Saturating count of cycles in which any part of the pipe was held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_event && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
